shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port i_clk input 1 as the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst input 1 as the reset: asynchronous, active-high.
REQ-004 SHALL have ports i_req_valid input 2, one bit per requester (0 = execute stage, 1 = load-align unit).
REQ-005 SHALL have ports i_req_a0/i_req_a1 input N each, operand to shift.
REQ-006 SHALL have ports i_req_b0/i_req_b1 input N each, shift amount; only bits [4:0] are used.
REQ-007 SHALL have ports i_req_op0/i_req_op1 input 2 each, operation: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
REQ-008 SHALL have port o_req_ready output 2, per-requester accept strobe.
REQ-009 SHALL have ports o_rsp_valid output 1, o_rsp_id output 1, o_rsp_data output N, o_rsp_err output 1, and i_rsp_ready input 1.

Function
REQ-010 SHALL contain one shared shift datapath (sll/srl/sra) computing the result from the granted request combinationally, with registered output.
REQ-011 SHALL implement SRA as arithmetic: vacated MSBs equal a[N-1]; SRL and SLL fill with 0.
REQ-012 SHALL ignore b[N-1:5]; shift amount 0 returns a unchanged.
REQ-013 SHALL, for op 11, register o_rsp_data = 0 and o_rsp_err = 1; otherwise o_rsp_err = 0.
REQ-014 SHALL use a 2-state FSM: EMPTY (output register free) and FULL (o_rsp_valid = 1).
REQ-015 SHALL define slot_free = EMPTY, or FULL with i_rsp_ready = 1 (same-cycle drain and refill).
REQ-016 SHALL arbitrate round-robin with a 1-bit pointer rr; when both valid, grant requester rr; when one valid, grant it.
REQ-017 SHALL assert o_req_ready[k] only for the granted requester, and only when slot_free; at most one bit set per cycle.
REQ-018 SHALL treat handshake k as fired when i_req_valid[k] and o_req_ready[k] are both 1.
REQ-019 SHALL, on a fire by k, load o_rsp_data/o_rsp_err/o_rsp_id = k next cycle, set rr = ~k, and go or stay FULL.
REQ-020 SHALL, in FULL with i_rsp_ready = 1 and no fire, go EMPTY and clear o_rsp_valid.
REQ-021 SHALL, in FULL with i_rsp_ready = 0, hold all o_rsp_* stable and keep o_req_ready = 00.
REQ-022 SHALL give latency 1 cycle from fire to o_rsp_valid, and sustain 1 result/cycle while i_rsp_ready = 1.
REQ-023 SHALL leave rr unchanged in cycles with no fire.
REQ-024 SHALL make o_req_ready independent of request payload (a, b, op), so it depends only on valid, rr, state and i_rsp_ready.
REQ-025 SHALL never drop or duplicate an accepted request; every fire produces exactly one response.

Reset
REQ-026 SHALL, while i_rst = 1, force state EMPTY, rr = 0, o_rsp_valid = 0, o_rsp_id = 0, o_rsp_data = 0, o_rsp_err = 0, and o_req_ready = 00, regardless of i_clk.
REQ-027 SHALL discard a response held in FULL when reset asserts mid-operation; none is presented after release.
REQ-028 SHALL allow a fire on the first rising edge after i_rst deasserts.

Verification
REQ-029 Bench SHALL cover single SRA: req0 a=0x80000010, b=4, op=10, i_rsp_ready=1 -> next cycle o_rsp_valid=1, id=0, data=0xF8000001, err=0.
REQ-030 Bench SHALL cover contention: both valid continuously after reset, i_rsp_ready=1 -> grants 0,1,0,1 on consecutive cycles; req1 a=0x80000000, b=0x21, op=01 -> data=0x40000000 (b[4:0]=1).
REQ-031 Bench SHALL cover backpressure: FULL with i_rsp_ready=0 for 3 cycles -> o_rsp_* stable and o_req_ready=00; when ready rises, same-cycle refill, with the next response on the following cycle.
REQ-032 Bench SHALL cover illegal op: op=11, a=0xFFFFFFFF -> data=0, err=1, rr still toggles.
REQ-033 Bench SHALL cover reset mid-operation: assert i_rst asynchronously while FULL -> o_rsp_valid=0 immediately; after release no stale response and rr=0.
REQ-034 Bench SHALL cover SLL by 31 (a=0x00000003 -> 0x80000000) and shift 0 (a unchanged), and SHALL run a randomized scoreboard comparing results to a reference shift model.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 32-bit shifter.
// The result sits in a single output register that can drain and refill in the same cycle.
module shift_arbiter #(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [1:0]   i_req_valid,
    input  logic [N-1:0] i_req_a0,
    input  logic [N-1:0] i_req_a1,
    input  logic [N-1:0] i_req_b0,
    input  logic [N-1:0] i_req_b1,
    input  logic [1:0]   i_req_op0,
    input  logic [1:0]   i_req_op1,
    output logic [1:0]   o_req_ready,
    output logic         o_rsp_valid,
    output logic         o_rsp_id,
    output logic [N-1:0] o_rsp_data,
    output logic         o_rsp_err,
    input  logic         i_rsp_ready
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic         r_rr;
    logic         r_rsp_id;
    logic [N-1:0] r_rsp_data;
    logic         r_rsp_err;

    logic         w_slot_free;
    logic         w_gid;
    logic         w_fire;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [1:0]   w_op;
    logic [4:0]   w_sh;
    logic [N-1:0] w_res;
    logic         w_err;

    // Grant depends only on valid, rr, state and i_rsp_ready, never on payload.
    always_comb begin
        o_req_ready  = 2'b00;
        w_state_next = r_state;
        w_slot_free  = (r_state == S_FULL) ? i_rsp_ready : 1'b1;
        w_gid        = (&i_req_valid) ? r_rr : i_req_valid[1];
        w_fire       = (|i_req_valid) & w_slot_free & ~i_rst;
        if (w_fire) begin
            o_req_ready[w_gid] = 1'b1;
        end
        if (w_fire) begin
            w_state_next = S_FULL;
        end else if ((r_state == S_FULL) && i_rsp_ready) begin
            w_state_next = S_EMPTY;
        end
    end

    always_comb begin
        w_a   = w_gid ? i_req_a1  : i_req_a0;
        w_b   = w_gid ? i_req_b1  : i_req_b0;
        w_op  = w_gid ? i_req_op1 : i_req_op0;
        // Upper shift-amount bits are architecturally ignored; folding them in as zero keeps them referenced.
        w_sh  = w_b[4:0] | {5{1'b0 & (^w_b[N-1:5])}};
        w_res = '0;
        w_err = 1'b0;
        case (w_op)
            2'b00:   w_res = w_a << w_sh;
            2'b01:   w_res = w_a >> w_sh;
            2'b10:   w_res = N'($signed(w_a) >>> w_sh);
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr       <= 1'b0;
            r_rsp_id   <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else if (w_fire) begin
            r_rr       <= ~w_gid;
            r_rsp_id   <= w_gid;
            r_rsp_data <= w_res;
            r_rsp_err  <= w_err;
        end
    end

    assign o_rsp_valid = (r_state == S_FULL);
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized checks of shift_arbiter: arbitration order, shift results,
// backpressure, illegal op and asynchronous reset behaviour.
`timescale 1ns/1ps
module tb_shift_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [1:0]  i_req_valid = 2'b00;
    logic [31:0] i_req_a0 = '0, i_req_a1 = '0, i_req_b0 = '0, i_req_b1 = '0;
    logic [1:0]  i_req_op0 = 2'b00, i_req_op1 = 2'b00;
    logic [1:0]  o_req_ready;
    logic        o_rsp_valid, o_rsp_id, o_rsp_err;
    logic [31:0] o_rsp_data;
    logic        i_rsp_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    shift_arbiter #(.N(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid),
        .i_req_a0(i_req_a0), .i_req_a1(i_req_a1), .i_req_b0(i_req_b0), .i_req_b1(i_req_b1),
        .i_req_op0(i_req_op0), .i_req_op1(i_req_op1), .o_req_ready(o_req_ready),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data),
        .o_rsp_err(o_rsp_err), .i_rsp_ready(i_rsp_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_req_valid = 2'b00;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    // Bit-by-bit reference: result bit i takes operand bit (i -/+ s) or the fill value.
    function automatic logic [32:0] ref_shift(input logic [31:0] a, input logic [4:0] s, input logic [1:0] op);
        logic [31:0] r;
        int src;
        r = '0;
        if (op == 2'b11) return {1'b1, 32'h0};
        for (int i = 0; i < 32; i++) begin
            src = (op == 2'b00) ? i - int'(s) : i + int'(s);
            if (src >= 0 && src < 32) r[i] = a[src];
            else if (op == 2'b10)     r[i] = a[31];
            else                      r[i] = 1'b0;
        end
        return {1'b0, r};
    endfunction

    task automatic test_reset();
        i_rst = 1'b1;
        i_req_valid = 2'b11;
        #3;
        total++; if (o_req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", o_req_ready); end
        tick();
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_rsp_valid); end
        total++; if (o_rsp_id !== 1'b0) begin bad++; $display("FAIL reset_id got=%b exp=0", o_rsp_id); end
        total++; if (o_rsp_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", o_rsp_data); end
        total++; if (o_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", o_rsp_err); end
        total++; if (o_req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready2 got=%b exp=00", o_req_ready); end
        i_req_valid = 2'b00;
        i_rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single_sra();
        do_reset();
        i_rsp_ready = 1'b1;
        i_req_a0 = 32'h80000010; i_req_b0 = 32'd4; i_req_op0 = 2'b10;
        i_req_valid = 2'b01;
        #1;
        total++; if (o_req_ready !== 2'b01) begin bad++; $display("FAIL sra_ready got=%b exp=01", o_req_ready); end
        tick();
        i_req_valid = 2'b00;
        #1;
        total++; if (o_rsp_valid !== 1'b1) begin bad++; $display("FAIL sra_valid got=%b exp=1", o_rsp_valid); end
        total++; if (o_rsp_id !== 1'b0) begin bad++; $display("FAIL sra_id got=%b exp=0", o_rsp_id); end
        total++; if (o_rsp_data !== 32'hF8000001) begin bad++; $display("FAIL sra_data got=%h exp=f8000001", o_rsp_data); end
        total++; if (o_rsp_err !== 1'b0) begin bad++; $display("FAIL sra_err got=%b exp=0", o_rsp_err); end
        total++; if (o_req_ready !== 2'b00) begin bad++; $display("FAIL sra_idle_ready got=%b exp=00", o_req_ready); end
        tick();
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL sra_drain got=%b exp=0", o_rsp_valid); end
        $display("test_single_sra: data=%h", 32'hF8000001);
    endtask

    task automatic test_contention();
        logic [31:0] exp_data;
        do_reset();
        i_rsp_ready = 1'b1;
        i_req_a0 = 32'h12345678; i_req_b0 = 32'h00000020; i_req_op0 = 2'b00;
        i_req_a1 = 32'h80000000; i_req_b1 = 32'h00000021; i_req_op1 = 2'b01;
        i_req_valid = 2'b11;
        #1;
        total++; if (o_req_ready !== 2'b01) begin bad++; $display("FAIL cont_first_ready got=%b exp=01", o_req_ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_data = (k % 2 == 0) ? 32'h12345678 : 32'h40000000;
            total++; if (o_rsp_valid !== 1'b1 || o_rsp_id !== 1'(k % 2)) begin
                bad++; $display("FAIL cont_grant%0d got valid=%b id=%b exp valid=1 id=%0d", k, o_rsp_valid, o_rsp_id, k % 2);
            end
            total++; if (o_rsp_data !== exp_data) begin bad++; $display("FAIL cont_data%0d got=%h exp=%h", k, o_rsp_data, exp_data); end
            total++; if (o_req_ready !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL cont_ready%0d got=%b", k, o_req_ready);
            end
            $display("contention cycle %0d id=%b data=%h", k, o_rsp_id, o_rsp_data);
        end
        i_req_valid = 2'b00;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        i_rsp_ready = 1'b0;
        i_req_a0 = 32'h00000003; i_req_b0 = 32'd31; i_req_op0 = 2'b00;
        i_req_valid = 2'b01;
        #1;
        total++; if (o_req_ready !== 2'b01) begin bad++; $display("FAIL bp_ready0 got=%b exp=01", o_req_ready); end
        tick();
        i_req_a0 = 32'h00000001; i_req_b0 = 32'd1;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (o_rsp_valid !== 1'b1 || o_rsp_id !== 1'b0 || o_rsp_data !== 32'h80000000 || o_rsp_err !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got valid=%b id=%b data=%h err=%b exp 1/0/80000000/0", k, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err);
            end
            total++; if (o_req_ready !== 2'b00) begin bad++; $display("FAIL bp_ready_stall%0d got=%b exp=00", k, o_req_ready); end
            tick();
        end
        i_rsp_ready = 1'b1;
        #1;
        total++; if (o_req_ready !== 2'b01) begin bad++; $display("FAIL bp_refill_ready got=%b exp=01", o_req_ready); end
        tick();
        i_req_valid = 2'b00;
        #1;
        total++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h00000002) begin
            bad++; $display("FAIL bp_next got valid=%b data=%h exp 1/00000002", o_rsp_valid, o_rsp_data);
        end
        $display("test_backpressure: refill data=%h", o_rsp_data);
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        i_rsp_ready = 1'b1;
        i_req_a0 = 32'hFFFFFFFF; i_req_b0 = 32'd3; i_req_op0 = 2'b11;
        i_req_valid = 2'b01;
        tick();
        i_req_op0 = 2'b00;
        i_req_valid = 2'b11;
        #1;
        total++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h0 || o_rsp_err !== 1'b1) begin
            bad++; $display("FAIL illegal_rsp got valid=%b data=%h err=%b exp 1/00000000/1", o_rsp_valid, o_rsp_data, o_rsp_err);
        end
        total++; if (o_req_ready !== 2'b10) begin bad++; $display("FAIL illegal_rr got=%b exp=10", o_req_ready); end
        tick();
        i_req_valid = 2'b00;
        #1;
        total++; if (o_rsp_err !== 1'b0 || o_rsp_id !== 1'b1) begin
            bad++; $display("FAIL illegal_clear got err=%b id=%b exp 0/1", o_rsp_err, o_rsp_id);
        end
        $display("test_illegal: err cleared on legal op");
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_rsp_ready = 1'b0;
        i_req_a0 = 32'h00000005; i_req_b0 = 32'd0; i_req_op0 = 2'b00;
        i_req_valid = 2'b01;
        tick();
        i_req_valid = 2'b00;
        #1;
        total++; if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h5) begin
            bad++; $display("FAIL mid_full got valid=%b data=%h exp 1/00000005", o_rsp_valid, o_rsp_data);
        end
        #1;
        i_rst = 1'b1;
        i_req_valid = 2'b01;
        #1;
        total++; if (o_rsp_valid !== 1'b0 || o_rsp_data !== 32'h0 || o_rsp_err !== 1'b0 || o_rsp_id !== 1'b0) begin
            bad++; $display("FAIL mid_async got valid=%b data=%h exp 0/00000000", o_rsp_valid, o_rsp_data);
        end
        total++; if (o_req_ready !== 2'b00) begin bad++; $display("FAIL mid_ready got=%b exp=00", o_req_ready); end
        tick();
        i_rst = 1'b0;
        i_rsp_ready = 1'b1;
        i_req_a0 = 32'h00000007; i_req_b0 = 32'd1; i_req_op0 = 2'b00;
        i_req_valid = 2'b11;
        #1;
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_stale got=%b exp=0", o_rsp_valid); end
        total++; if (o_req_ready !== 2'b01) begin bad++; $display("FAIL mid_rr got=%b exp=01", o_req_ready); end
        tick();
        i_req_valid = 2'b00;
        #1;
        total++; if (o_rsp_valid !== 1'b1 || o_rsp_id !== 1'b0 || o_rsp_data !== 32'h0000000E) begin
            bad++; $display("FAIL mid_first_fire got valid=%b id=%b data=%h exp 1/0/0000000e", o_rsp_valid, o_rsp_id, o_rsp_data);
        end
        $display("test_reset_mid: first fire data=%h", o_rsp_data);
        tick();
    endtask

    task automatic test_random();
        logic [32:0] exp;
        logic [1:0]  v;
        logic        rr, gid;
        do_reset();
        i_rsp_ready = 1'b1;
        rr = 1'b0;
        for (int k = 0; k < 40; k++) begin
            v = 2'($urandom_range(1, 3));
            i_req_a0 = $urandom; i_req_b0 = $urandom; i_req_op0 = 2'($urandom_range(0, 3));
            i_req_a1 = $urandom; i_req_b1 = $urandom; i_req_op1 = 2'($urandom_range(0, 3));
            i_req_valid = v;
            gid = (v == 2'b11) ? rr : v[1];
            exp = gid ? ref_shift(i_req_a1, i_req_b1[4:0], i_req_op1) : ref_shift(i_req_a0, i_req_b0[4:0], i_req_op0);
            #1;
            total++; if (o_req_ready !== (gid ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL rand_ready%0d got=%b gid=%b", k, o_req_ready, gid);
            end
            tick();
            rr = ~gid;
            total++; if (o_rsp_valid !== 1'b1 || o_rsp_id !== gid || o_rsp_err !== exp[32] || o_rsp_data !== exp[31:0]) begin
                bad++; $display("FAIL rand_rsp%0d got id=%b err=%b data=%h exp id=%b err=%b data=%h", k, o_rsp_id, o_rsp_err, o_rsp_data, gid, exp[32], exp[31:0]);
            end
            $display("random %0d id=%b data=%h err=%b", k, o_rsp_id, o_rsp_data, o_rsp_err);
        end
        i_req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_sra();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
